// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and constants for the LED pattern sequencer: mode encoding,
// button bit positions and the mode/step to LED decode.
package led_seq_pkg;

   typedef enum logic [1:0] {
      BOUNCE = 2'd0,
      BLINK  = 2'd1,
      COUNT  = 2'd2,
      OFF    = 2'd3
   } mode_t;

   localparam int BTN_NEXT   = 1;
   localparam int BTN_PREV   = 2;
   localparam int BTN_PAUSE  = 3;
   localparam int BTN_FASTER = 4;
   localparam int BTN_SLOWER = 5;

   localparam logic [1:0] SPEED_MAX = 2'd3;
   localparam logic [7:0] LED_RESET = 8'h01;

   // Bounce walks 0..7 on step[3]=0 and mirrors 7..0 on step[3]=1; 7-pos is ~pos in 3 bits.
   function automatic logic [7:0] led_decode(input logic [1:0] mode, input logic [7:0] step);
      logic [2:0] pos;
      led_decode = 8'h00;
      pos        = step[3] ? ~step[2:0] : step[2:0];
      case (mode)
         BOUNCE:  led_decode = 8'h01 << pos;
         BLINK:   led_decode = step[0] ? 8'hFF : 8'h00;
         COUNT:   led_decode = step;
         default: led_decode = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Board-side bundle of the LED sequencer: raw buttons in, LED drive and status out.
interface led_seq_if;
   logic [6:0] btn;
   logic [7:0] led;
   logic [1:0] mode;
   logic       run;

   modport master (output btn, input led, input mode, input run);
   modport slave  (input btn, output led, output mode, output run);
endinterface

// File: rtl/led_pattern_sequencer_btn_debounce.sv
// One button: 2-FF synchroniser, stable-count debouncer and rising-edge press pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 2**16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta_p0;
   logic          sync_p1;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         level_q <= 1'b0;
         level_d <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_p0 <= btn;
         sync_p1 <= meta_p0;
         level_d <= level_q;
         // Count consecutive samples that disagree with the accepted level.
         if (sync_p1 == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            level_q <= sync_p1;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign press = level_q & ~level_d;

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bank controller: button presses drive mode/speed/pause; one prescaler times every animation.
module led_pattern_sequencer
   import led_seq_pkg::*;
#(
   parameter int TICK_DIV        = 2**20,
   parameter int DEBOUNCE_CYCLES = 2**16
) (
   input  logic      clk,
   input  logic      rst,
   led_seq_if.slave  io
);

   localparam int PW = $clog2(TICK_DIV);

   localparam logic [1:0] MODE_BOUNCE = BOUNCE;

   logic [BTN_SLOWER:BTN_NEXT] press;
   logic                       unused_btn;

   logic [1:0]    mode_q;
   logic          run_q;
   logic [1:0]    speed_q;
   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_last;
   logic [7:0]    step_q;
   logic [7:0]    led_q;

   logic go_next;
   logic go_prev;
   logic mode_chg;
   logic go_faster;
   logic go_slower;
   logic tick;

   assign unused_btn = io.btn[0] ^ io.btn[6];

   for (genvar g = BTN_NEXT; g <= BTN_SLOWER; g++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .btn   (io.btn[g]),
         .press (press[g])
      );
   end

   assign go_next   = press[BTN_NEXT] & ~press[BTN_PREV];
   assign go_prev   = press[BTN_PREV] & ~press[BTN_NEXT];
   assign mode_chg  = go_next | go_prev;
   assign go_faster = press[BTN_FASTER] & ~press[BTN_SLOWER] & (speed_q != SPEED_MAX);
   assign go_slower = press[BTN_SLOWER] & ~press[BTN_FASTER] & (speed_q != 2'd0);

   // >= rather than == so a speed-up past the current count ticks at once instead of wrapping.
   assign presc_last = PW'((TICK_DIV >> speed_q) - 1);
   assign tick       = run_q & (presc_q >= presc_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= MODE_BOUNCE;
         run_q   <= 1'b1;
         speed_q <= 2'd0;
      end else begin
         if (go_next) begin
            mode_q <= mode_q + 2'd1;
         end else if (go_prev) begin
            mode_q <= mode_q - 2'd1;
         end
         if (press[BTN_PAUSE]) begin
            run_q <= ~run_q;
         end
         if (go_faster) begin
            speed_q <= speed_q + 2'd1;
         end else if (go_slower) begin
            speed_q <= speed_q - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         step_q  <= 8'd0;
      end else if (mode_chg) begin
         presc_q <= '0;
         step_q  <= 8'd0;
      end else if (tick) begin
         presc_q <= '0;
         step_q  <= step_q + 8'd1;
      end else if (run_q) begin
         presc_q <= presc_q + PW'(1);
      end
   end

   // LED stage: decode lags step/mode by one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_q <= LED_RESET;
      end else begin
         led_q <= led_decode(mode_q, step_q);
      end
   end

   assign io.led  = led_q;
   assign io.mode = mode_q;
   assign io.run  = run_q;

endmodule
